// File: rtl/lisnoc_pkg.sv
// Flit type codes and header field layout. The router uses the same
// definitions, so a packet built here is decoded there without translation.
package lisnoc_pkg;

   localparam logic [1:0] FLIT_TYPE_PAYLOAD = 2'b00;
   localparam logic [1:0] FLIT_TYPE_HEADER  = 2'b01;
   localparam logic [1:0] FLIT_TYPE_LAST    = 2'b10;
   localparam logic [1:0] FLIT_TYPE_SINGLE  = 2'b11;

   // Destination sits in the MSBs of the header data word; the rest is user header.
   localparam int HDR_DEST_MSB_OFS = 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HEADER  = 2'd1,
      ST_PAYLOAD = 2'd2
   } tx_state_t;

endpackage

// File: rtl/lisnoc_packet_tx_if.sv
// Descriptor, payload and link signals of the packet transmitter.
// slave is the transmitter's view; master is the client/router-side view.
interface lisnoc_packet_tx_if #(
   parameter int flit_data_width = 32,
   parameter int flit_type_width = 2,
   parameter int destwidth       = 5,
   parameter int vchannels       = 1,
   parameter int lenwidth        = 8
) ();
   localparam int flit_width = flit_data_width + flit_type_width;
   localparam int vc_width   = (vchannels > 1) ? $clog2(vchannels) : 1;

   logic [destwidth-1:0]                 req_dest_i;
   logic [flit_data_width-destwidth-1:0] req_hdr_i;
   logic [lenwidth-1:0]                  req_len_i;
   logic [vc_width-1:0]                  req_vc_i;
   logic                                 req_valid_i;
   logic                                 req_ready_o;

   logic [flit_data_width-1:0]           data_i;
   logic                                 data_valid_i;
   logic                                 data_ready_o;

   logic [flit_width-1:0]                flit_o;
   logic [vchannels-1:0]                 valid_o;
   logic [vchannels-1:0]                 ready_i;

   modport slave (
      input  req_dest_i, req_hdr_i, req_len_i, req_vc_i, req_valid_i,
      output req_ready_o,
      input  data_i, data_valid_i,
      output data_ready_o,
      output flit_o, valid_o,
      input  ready_i
   );

   modport master (
      output req_dest_i, req_hdr_i, req_len_i, req_vc_i, req_valid_i,
      input  req_ready_o,
      output data_i, data_valid_i,
      input  data_ready_o,
      input  flit_o, valid_o,
      output ready_i
   );

endinterface

// File: rtl/lisnoc_packet_tx.sv
// Packetizer: turns a descriptor plus a stream of payload words into
// HEADER/PAYLOAD/LAST (or SINGLE) flits on one virtual channel of a link.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for a descriptor; header loads on the accept edge
// ST_HEADER  | header load step, folded into the IDLE accept edge (never held)
// ST_PAYLOAD | accepting payload words, r_cnt = words still to come
module lisnoc_packet_tx
   import lisnoc_pkg::*;
#(
   parameter int flit_data_width = 32,
   parameter int flit_type_width = 2,
   parameter int destwidth       = 5,
   parameter int vchannels       = 1,
   parameter int lenwidth        = 8
) (
   input  logic              clk,
   input  logic              rst,
   lisnoc_packet_tx_if.slave bus
);

   localparam int flit_width = flit_data_width + flit_type_width;
   localparam int vc_width   = (vchannels > 1) ? $clog2(vchannels) : 1;

   tx_state_t               r_state;
   tx_state_t               w_state_nxt;
   logic [lenwidth-1:0]     r_cnt;
   logic [lenwidth-1:0]     w_cnt_nxt;
   logic [vc_width-1:0]     r_vc;
   logic [vc_width-1:0]     w_vc_nxt;
   logic [flit_width-1:0]   r_flit;
   logic [flit_width-1:0]   w_flit_nxt;
   logic                    r_valid;
   logic                    w_load;
   logic                    w_req_ready;
   logic                    w_data_ready;
   logic [vchannels-1:0]    w_vc_onehot;
   logic                    w_xfer;
   logic                    w_free;

   assign w_vc_onehot = vchannels'(1) << r_vc;
   assign w_xfer      = r_valid & (|(bus.ready_i & w_vc_onehot));
   // The register can take a new flit if empty or if its current flit leaves now.
   assign w_free      = ~r_valid | w_xfer;

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_vc_nxt     = r_vc;
      w_flit_nxt   = r_flit;
      w_load       = 1'b0;
      w_req_ready  = 1'b0;
      w_data_ready = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_req_ready = w_free;
            if (bus.req_valid_i && w_free) begin
               w_load    = 1'b1;
               w_vc_nxt  = bus.req_vc_i;
               w_cnt_nxt = bus.req_len_i;
               if (bus.req_len_i == '0) begin
                  w_flit_nxt = {flit_type_width'(FLIT_TYPE_SINGLE), bus.req_dest_i, bus.req_hdr_i};
               end else begin
                  w_flit_nxt  = {flit_type_width'(FLIT_TYPE_HEADER), bus.req_dest_i, bus.req_hdr_i};
                  w_state_nxt = ST_PAYLOAD;
               end
            end
         end
         ST_PAYLOAD: begin
            w_data_ready = w_free;
            if (bus.data_valid_i && w_free) begin
               w_load    = 1'b1;
               w_cnt_nxt = r_cnt - lenwidth'(1);
               if (r_cnt == lenwidth'(1)) begin
                  w_flit_nxt  = {flit_type_width'(FLIT_TYPE_LAST), bus.data_i};
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_flit_nxt = {flit_type_width'(FLIT_TYPE_PAYLOAD), bus.data_i};
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_vc    <= '0;
         r_flit  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_vc    <= w_vc_nxt;
         if (w_load) begin
            r_flit  <= w_flit_nxt;
            r_valid <= 1'b1;
         end else if (w_xfer) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign bus.req_ready_o  = w_req_ready;
   assign bus.data_ready_o = w_data_ready;
   assign bus.flit_o       = r_flit;
   assign bus.valid_o      = r_valid ? w_vc_onehot : '0;

endmodule
